// File: rtl/avalon_bank_arbiter.sv
// Two-requester round-robin arbiter that sequences write/read commands onto a
// single Avalon-MM register-bank slave with one-cycle registered read latency.
module avalon_bank_arbiter #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic              iWr0,
    input  logic              iWr1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWdata0,
    input  logic [DATA_W-1:0] iWdata1,
    output logic              oAck0,
    output logic              oAck1,
    output logic [DATA_W-1:0] oRdata0,
    output logic [DATA_W-1:0] oRdata1,
    output logic              oChipselect,
    output logic              oWrite_n,
    output logic              oRead_n,
    output logic [ADDR_W-1:0] oAddress,
    output logic [DATA_W-1:0] oData,
    input  logic [DATA_W-1:0] iData,
    output logic [1:0]        oGrant,
    output logic              oBusy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          grant_q, grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic                read_n_q, read_n_d;
    logic [1:0]          ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                any_req_c;
    logic                pick1_c;
    logic                sel_wr_c;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign any_req_c = iReq0 | iReq1;
    assign pick1_c   = (iReq0 & iReq1) ? ~last_q : iReq1;
    assign sel_wr_c  = pick1_c ? iWr1 : iWr0;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        read_n_d  = 1'b1;
        ack_d     = 2'b00;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    last_d    = pick1_c;
                    grant_d   = pick1_c ? 2'b10 : 2'b01;
                    wr_d      = sel_wr_c;
                    addr_d    = pick1_c ? iAddr1 : iAddr0;
                    data_d    = pick1_c ? iWdata1 : iWdata0;
                    cs_d      = 1'b1;
                    write_n_d = ~sel_wr_c;
                    read_n_d  = sel_wr_c;
                    busy_d    = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    ack_d   = grant_q;
                    state_d = S_ACK;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                // Slave read data is valid during this cycle.
                if (grant_q[0]) begin
                    rdata0_d = iData;
                end else begin
                    rdata1_d = iData;
                end
                ack_d   = grant_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            read_n_q  <= 1'b1;
            ack_q     <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            read_n_q  <= read_n_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign oAck0       = ack_q[0];
    assign oAck1       = ack_q[1];
    assign oRdata0     = rdata0_q;
    assign oRdata1     = rdata1_q;
    assign oChipselect = cs_q;
    assign oWrite_n    = write_n_q;
    assign oRead_n     = read_n_q;
    assign oAddress    = addr_q;
    assign oData       = data_q;
    assign oGrant      = grant_q;
    assign oBusy       = busy_q;

endmodule

// File: tb/tb_avalon_bank_arbiter.sv
// Self-checking bench for avalon_bank_arbiter: slave register-bank model plus a
// transaction-level reference (memory contents, per-requester read results, latencies).
module tb_avalon_bank_arbiter;

    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic        iReq0 = 1'b0, iReq1 = 1'b0;
    logic        iWr0 = 1'b0, iWr1 = 1'b0;
    logic [1:0]  iAddr0 = 2'd0, iAddr1 = 2'd0;
    logic [31:0] iWdata0 = 32'd0, iWdata1 = 32'd0;
    logic        oAck0, oAck1;
    logic [31:0] oRdata0, oRdata1;
    logic        oChipselect, oWrite_n, oRead_n;
    logic [1:0]  oAddress;
    logic [31:0] oData;
    logic [31:0] iData;
    logic [1:0]  oGrant;
    logic        oBusy;

    avalon_bank_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .iClk(iClk), .iReset(iReset),
        .iReq0(iReq0), .iReq1(iReq1), .iWr0(iWr0), .iWr1(iWr1),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iWdata0(iWdata0), .iWdata1(iWdata1),
        .oAck0(oAck0), .oAck1(oAck1), .oRdata0(oRdata0), .oRdata1(oRdata1),
        .oChipselect(oChipselect), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
        .oAddress(oAddress), .oData(oData), .iData(iData),
        .oGrant(oGrant), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    // Register-bank slave: writes on strobe, read data registered one cycle later.
    logic [31:0] slave_mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] slave_q = 32'h0;
    int          slave_strobes = 0;
    assign iData = slave_q;
    always @(posedge iClk) begin
        if (oChipselect && !oWrite_n) slave_mem[oAddress] <= oData;
        if (oChipselect && !oRead_n) slave_q <= slave_mem[oAddress];
        if (oChipselect) slave_strobes <= slave_strobes + 1;
    end

    // Reference model state
    logic [31:0] ref_mem [0:3];
    logic [31:0] ref_rd  [0:1];

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [74:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};

    // Observations of the last run_cmd transaction
    int          obs_cs_k, obs_cs_n, obs_ack_k, obs_other_ack, obs_multi_ack;
    logic [1:0]  obs_addr, obs_grant;
    logic [31:0] obs_data, obs_rd0, obs_rd1;
    logic        obs_wr_n, obs_rd_n, obs_idle;

    function automatic logic [74:0] out_vec();
        return {oChipselect, oWrite_n, oRead_n, oAddress, oData, oAck0, oAck1, oGrant, oBusy,
                oRdata0 | oRdata1};
    endfunction

    task automatic set_req(input int r, input logic v, input logic wr,
                           input logic [1:0] a, input logic [31:0] d);
        if (r == 0) begin
            iReq0 = v; iWr0 = wr; iAddr0 = a; iWdata0 = d;
        end else begin
            iReq1 = v; iWr1 = wr; iAddr1 = a; iWdata1 = d;
        end
    endtask

    // Issue one command from an idle DUT; k counts edges after the sampling edge.
    task automatic run_cmd(input int r, input logic wr, input logic [1:0] a, input logic [31:0] d);
        obs_cs_k = -1; obs_cs_n = 0; obs_ack_k = -1; obs_other_ack = 0; obs_multi_ack = 0;
        set_req(r, 1'b1, wr, a, d);
        for (int k = 0; k < 20; k++) begin
            @(posedge iClk); #1;
            if (oAck0 && oAck1) obs_multi_ack++;
            if (oChipselect) begin
                obs_cs_n++;
                if (obs_cs_k < 0) begin
                    obs_cs_k = k; obs_addr = oAddress; obs_data = oData;
                    obs_wr_n = oWrite_n; obs_rd_n = oRead_n; obs_grant = oGrant;
                end
            end
            if ((r == 0) ? oAck0 : oAck1) begin
                obs_ack_k = k; obs_rd0 = oRdata0; obs_rd1 = oRdata1;
                break;
            end
            if ((r == 0) ? oAck1 : oAck0) obs_other_ack++;
        end
        set_req(r, 1'b0, wr, a, d);
        @(posedge iClk); #1;
        obs_idle = !oBusy && (oGrant == 2'b00) && !oAck0 && !oAck1 && !oChipselect;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
        iReset = 1'b0;
        @(posedge iClk); #1;
        tests_run++;
        if (out_vec() !== RESET_VEC) begin
            tests_failed++; $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
        end
        iReset = 1'b1;
        @(posedge iClk); #1;
        set_req(0, 1'b1, 1'b1, 2'd1, 32'hCAFE0001);
        @(posedge iClk); #1;
        tests_run++;
        if (oChipselect !== 1'b1 || oBusy !== 1'b1) begin
            tests_failed++; $display("FAIL reset_pre_issue: got cs=%b busy=%b expected 1 1", oChipselect, oBusy);
        end
        #2 iReset = 1'b0;
        #1;
        tests_run++;
        if (out_vec() !== RESET_VEC) begin
            tests_failed++; $display("FAIL reset_async: got %h expected %h", out_vec(), RESET_VEC);
        end
        set_req(0, 1'b0, 1'b1, 2'd1, 32'hCAFE0001);
        @(posedge iClk); #1;
        tests_run++;
        if (slave_mem[1] !== ref_mem[1] || out_vec() !== RESET_VEC) begin
            tests_failed++; $display("FAIL reset_drop_write: got mem1=%h out=%h expected mem1=%h", slave_mem[1], out_vec(), ref_mem[1]);
        end
        iReset = 1'b1;
        @(posedge iClk); #1;
    endtask

    task automatic test_wr_rd_r0();
        run_cmd(0, 1'b1, 2'd2, 32'hDEADBEEF);
        ref_mem[2] = 32'hDEADBEEF;
        tests_run++;
        if ({obs_cs_k, obs_cs_n, obs_ack_k} !== {32'sd0, 32'sd1, 32'sd1}) begin
            tests_failed++; $display("FAIL wr0_timing: got cs_k=%0d cs_n=%0d ack_k=%0d expected 0 1 1", obs_cs_k, obs_cs_n, obs_ack_k);
        end
        tests_run++;
        if ({obs_wr_n, obs_rd_n, obs_addr, obs_data, obs_grant} !== {1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 2'b01}) begin
            tests_failed++; $display("FAIL wr0_strobe: got wr_n=%b rd_n=%b addr=%0d data=%h grant=%b expected 0 1 2 deadbeef 01", obs_wr_n, obs_rd_n, obs_addr, obs_data, obs_grant);
        end
        tests_run++;
        if (obs_idle !== 1'b1 || obs_other_ack != 0) begin
            tests_failed++; $display("FAIL wr0_idle: got idle=%b other_ack=%0d expected 1 0", obs_idle, obs_other_ack);
        end
        run_cmd(0, 1'b0, 2'd2, 32'h0);
        ref_rd[0] = ref_mem[2];
        tests_run++;
        if ({obs_cs_k, obs_cs_n, obs_ack_k} !== {32'sd0, 32'sd1, 32'sd2} || obs_wr_n !== 1'b1 || obs_rd_n !== 1'b0) begin
            tests_failed++; $display("FAIL rd0_timing: got cs_k=%0d cs_n=%0d ack_k=%0d wr_n=%b rd_n=%b expected 0 1 2 1 0", obs_cs_k, obs_cs_n, obs_ack_k, obs_wr_n, obs_rd_n);
        end
        tests_run++;
        if (obs_rd0 !== ref_rd[0] || obs_rd1 !== ref_rd[1]) begin
            tests_failed++; $display("FAIL rd0_data: got rd0=%h rd1=%h expected %h %h", obs_rd0, obs_rd1, ref_rd[0], ref_rd[1]);
        end
    endtask

    task automatic test_all_addr();
        for (int a = 0; a < 4; a++) begin
            run_cmd(1, 1'b1, 2'(a), 32'(32'h11111111 * (a + 1)));
            ref_mem[a] = 32'(32'h11111111 * (a + 1));
            tests_run++;
            if (obs_ack_k != 1 || obs_grant !== 2'b10 || obs_addr !== 2'(a)) begin
                tests_failed++; $display("FAIL addr_wr%0d: got ack_k=%0d grant=%b addr=%0d expected 1 10 %0d", a, obs_ack_k, obs_grant, obs_addr, a);
            end
        end
        for (int a = 0; a < 4; a++) begin
            run_cmd(1, 1'b0, 2'(a), 32'h0);
            ref_rd[1] = ref_mem[a];
            tests_run++;
            if (obs_ack_k != 2 || obs_rd1 !== ref_rd[1] || obs_rd0 !== ref_rd[0]) begin
                tests_failed++; $display("FAIL addr_rd%0d: got ack_k=%0d rd1=%h rd0=%h expected 2 %h %h", a, obs_ack_k, obs_rd1, obs_rd0, ref_rd[1], ref_rd[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int round = 0; round < 2; round++) begin
            logic [1:0] order [$];
            int  multi = 0;
            logic done0 = 1'b0, done1 = 1'b0;
            set_req(0, 1'b1, 1'b0, 2'd0, 32'h0);
            set_req(1, 1'b1, 1'b0, 2'd3, 32'h0);
            for (int k = 0; k < 30 && !(done0 && done1); k++) begin
                @(posedge iClk); #1;
                if (oChipselect) order.push_back(oGrant);
                if (oAck0 && oAck1) multi++;
                if (oAck0) begin done0 = 1'b1; set_req(0, 1'b0, 1'b0, 2'd0, 32'h0); end
                if (oAck1) begin done1 = 1'b1; set_req(1, 1'b0, 1'b0, 2'd3, 32'h0); end
            end
            set_req(0, 1'b0, 1'b0, 2'd0, 32'h0);
            set_req(1, 1'b0, 1'b0, 2'd3, 32'h0);
            @(posedge iClk); #1;
            ref_rd[0] = ref_mem[0]; ref_rd[1] = ref_mem[3];
            tests_run++;
            if (order.size() != 2 || order[0] !== 2'b01 || order[1] !== 2'b10 || multi != 0) begin
                tests_failed++; $display("FAIL tie_order_r%0d: got n=%0d first=%b second=%b multi=%0d expected 2 01 10 0", round, order.size(), (order.size() > 0) ? order[0] : 2'bxx, (order.size() > 1) ? order[1] : 2'bxx, multi);
            end
            tests_run++;
            if (oRdata0 !== ref_rd[0] || oRdata1 !== ref_rd[1]) begin
                tests_failed++; $display("FAIL tie_data_r%0d: got %h %h expected %h %h", round, oRdata0, oRdata1, ref_rd[0], ref_rd[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cs_k [$];
        int ack_k [$];
        set_req(0, 1'b1, 1'b1, 2'd1, 32'hB2B00001);
        for (int k = 0; k < 20 && ack_k.size() < 2; k++) begin
            @(posedge iClk); #1;
            if (oChipselect) cs_k.push_back(k);
            if (oAck0) begin
                ack_k.push_back(k);
                if (ack_k.size() == 1) set_req(0, 1'b1, 1'b0, 2'd1, 32'h0);
                else set_req(0, 1'b0, 1'b0, 2'd1, 32'h0);
            end
        end
        set_req(0, 1'b0, 1'b0, 2'd1, 32'h0);
        ref_mem[1] = 32'hB2B00001;
        ref_rd[0] = ref_mem[1];
        tests_run++;
        if (cs_k.size() != 2 || ack_k.size() != 2 || cs_k[0] != 0 || ack_k[0] != 1 || cs_k[1] != ack_k[0] + 2 || ack_k[1] != 5) begin
            tests_failed++; $display("FAIL b2b_timing: got n_cs=%0d n_ack=%0d cs1=%0d ack2=%0d expected 2 2 3 5", cs_k.size(), ack_k.size(), (cs_k.size() > 1) ? cs_k[1] : -1, (ack_k.size() > 1) ? ack_k[1] : -1);
        end
        tests_run++;
        if (oRdata0 !== ref_rd[0]) begin
            tests_failed++; $display("FAIL b2b_data: got %h expected %h", oRdata0, ref_rd[0]);
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_reset_rwait();
        int strobes;
        int bad = 0;
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h0);
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        tests_run++;
        if (oChipselect !== 1'b0 || oBusy !== 1'b1 || oAck0 !== 1'b0) begin
            tests_failed++; $display("FAIL rwait_state: got cs=%b busy=%b ack=%b expected 0 1 0", oChipselect, oBusy, oAck0);
        end
        #2 iReset = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h0);
        #1;
        ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
        tests_run++;
        if (out_vec() !== RESET_VEC || oRdata0 !== ref_rd[0] || oRdata1 !== ref_rd[1]) begin
            tests_failed++; $display("FAIL rwait_reset: got %h rd0=%h rd1=%h expected %h 0 0", out_vec(), oRdata0, oRdata1, RESET_VEC);
        end
        strobes = slave_strobes;
        for (int k = 0; k < 2; k++) begin
            @(posedge iClk); #1;
            if (oAck0 || oAck1 || oChipselect) bad++;
        end
        iReset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge iClk); #1;
            if (oAck0 || oAck1 || oChipselect) bad++;
        end
        tests_run++;
        if (bad != 0 || slave_strobes != strobes) begin
            tests_failed++; $display("FAIL rwait_quiet: got bad=%0d strobes=%0d expected 0 %0d", bad, slave_strobes, strobes);
        end
        run_cmd(0, 1'b0, 2'd2, 32'h0);
        ref_rd[0] = ref_mem[2];
        tests_run++;
        if (obs_ack_k != 2 || obs_rd0 !== ref_rd[0] || obs_rd1 !== ref_rd[1]) begin
            tests_failed++; $display("FAIL rwait_reissue: got ack_k=%0d rd0=%h rd1=%h expected 2 %h %h", obs_ack_k, obs_rd0, obs_rd1, ref_rd[0], ref_rd[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int          r  = int'($urandom_range(0, 1));
            logic        wr = 1'($urandom_range(0, 1));
            logic [1:0]  a  = 2'($urandom_range(0, 3));
            logic [31:0] d  = $urandom;
            int          exp_lat;
            run_cmd(r, wr, a, d);
            if (wr) ref_mem[a] = d;
            else ref_rd[r] = ref_mem[a];
            exp_lat = wr ? 1 : 2;
            tests_run++;
            if (obs_ack_k != exp_lat || obs_cs_n != 1 || obs_addr !== a || obs_grant !== ((r == 0) ? 2'b01 : 2'b10)
                || (wr && obs_data !== d) || obs_other_ack != 0 || obs_multi_ack != 0 || obs_idle !== 1'b1) begin
                tests_failed++; $display("FAIL rand%0d_cmd: got ack_k=%0d cs_n=%0d addr=%0d grant=%b data=%h expected %0d 1 %0d req%0d %h", i, obs_ack_k, obs_cs_n, obs_addr, obs_grant, obs_data, exp_lat, a, r, d);
            end
            tests_run++;
            if (obs_rd0 !== ref_rd[0] || obs_rd1 !== ref_rd[1]) begin
                tests_failed++; $display("FAIL rand%0d_data: got %h %h expected %h %h", i, obs_rd0, obs_rd1, ref_rd[0], ref_rd[1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wr_rd_r0();
        test_all_addr();
        test_simultaneous();
        test_back_to_back();
        test_reset_rwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/avalon_bank_arbiter.md
# avalon_bank_arbiter

Two-requester round-robin arbiter and sequencer for a single Avalon-MM register-bank slave: 2-bit address, 32-bit data, one-cycle registered read latency. It accepts a write or read command from either of two requesters, such as the CPU bridge and the test DMA. It issues each command on the shared slave port as a one-cycle chipselect strobe and returns read data with a one-cycle acknowledge. It sits between the requesters and the slave's `iChipselect/iWrite_n/iRead_n/iAddress/iData/oData` port.

## Interface
- `ADDR_W`, 2, slave address width
- `DATA_W`, 32, data width
- `iClk` in 1 — the block's only clock; everything is sampled on its rising edge
- `iReset` in 1 — asynchronous, active-low reset
- `iReq0` / `iReq1` in 1 — command valid; requester N holds it until `oAckN`
- `iWr0` / `iWr1` in 1 — 1 = write, 0 = read
- `iAddr0` / `iAddr1` in `ADDR_W` — command address
- `iWdata0` / `iWdata1` in `DATA_W` — write data
- `oAck0` / `oAck1` out 1 — one-cycle completion pulse
- `oRdata0` / `oRdata1` out `DATA_W` — last read result for that requester
- `oChipselect` out 1 — to slave `iChipselect`
- `oWrite_n` out 1 — to slave `iWrite_n`
- `oRead_n` out 1 — to slave `iRead_n`
- `oAddress` out `ADDR_W` — to slave `iAddress`
- `oData` out `DATA_W` — to slave `iData`
- `iData` in `DATA_W` — from slave `oData`
- `oGrant` out 2 — one-hot owner of the current transaction, 0 when idle
- `oBusy` out 1 — high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, RWAIT, ACK.
- **IDLE**
  - Samples `iReq0`/`iReq1`. With no request, stays in IDLE.
  - With one request, grants that requester.
  - With both, grants the requester that was not granted last.
  - Round-robin pointer `last` resets to 1, so requester 0 wins the first tie.
  - On grant: latch wr/addr/wdata, set `oGrant`, update `last`, go to ISSUE.
- **ISSUE**
  - Exactly one cycle with `oChipselect`=1 and `oAddress`/`oData` = latched values.
  - Write: `oWrite_n`=0, `oRead_n`=1, next state ACK.
  - Read: `oWrite_n`=1, `oRead_n`=0, next state RWAIT.
- **RWAIT**
  - Strobes inactive.
  - Slave `oData` is valid on `iData`; captured into `oRdataN` of the granted requester at the edge ending RWAIT.
  - Next state ACK.
- **ACK**
  - `oAckN`=1 for the granted requester only; strobes inactive.
  - Next state IDLE. `oGrant` clears on entering IDLE.
- Requests are not sampled in ISSUE, RWAIT or ACK; command inputs are ignored outside IDLE.
- Requester protocol:
  - Command fields must be stable from `iReqN` rise until `oAckN`.
  - `iReqN` still high at the edge ending the ACK cycle is a new command.
- `oRdataN` holds its value until the next read granted to N. Writes and the other requester's reads never change it.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Strobe inactive levels: `oChipselect`=0, `oWrite_n`=1, `oRead_n`=1. `oAddress`/`oData` hold their last values when inactive.

## Timing
- Reset (asynchronous, immediate on `iReset`=0), all outputs:
  - `oChipselect`=0, `oWrite_n`=1, `oRead_n`=1
  - `oAddress`=0, `oData`=0
  - `oAck0`=`oAck1`=0, `oRdata0`=`oRdata1`=0
  - `oGrant`=0, `oBusy`=0
  - FSM=IDLE, `last`=1
- Reset mid-transaction:
  - Any in-flight command is dropped with no ack; the requester must reissue.
  - Strobes drop in the same instant.
- Latency, with the request sampled at edge E0 in IDLE:
  - ISSUE is cycle 1.
  - Write: `oAck` in cycle 2.
  - Read: RWAIT is cycle 2, `oAck` in cycle 3, with `oRdata` valid in that same cycle 3.
- Throughput: write 3 cycles per transaction, read 4 cycles (IDLE included).
- Both requesters held high continuously: grants strictly alternate 0,1,0,1,… and no requester starves.
- Only one requester active: it is granted every IDLE regardless of `last`.
- At most one `oAck` high in any cycle.

## Test plan
- **Reset values:** assert `iReset`=0 mid-simulation → every output at its reset value immediately, without waiting for an `iClk` edge.
- **Write then read, requester 0:**
  - Stimulus: write 0xDEADBEEF to addr 2, then read addr 2.
  - Required: single-cycle strobe pulses only.
  - Required: write `oAck0` 2 cycles after grant; read `oAck0` 3 cycles after grant.
  - Required: `oRdata0`=0xDEADBEEF; `oRdata1` stays 0.
- **All addresses:** requester 1 writes 0x11111111·(a+1) to addr a=0..3, then reads all four back → each read matches, including addr 3 (max address).
- **Simultaneous requests:** `iReq0` and `iReq1` both rise in the same cycle after reset, both reading → requester 0 granted first, then requester 1; a repeat tie grants 0 again after 1.
- **Back-to-back:** requester 0 keeps `iReq0` high through ACK with a new command while requester 1 is idle → second ISSUE starts 2 cycles after the first ack.
- **Reset during RWAIT:** reset pulse → no `oAck`, `oRdata` reset to 0. After release, reissuing the read completes normally. The slave model must not see a strobe after reset.
